// File: rtl/i2c_target_engine.sv
`timescale 1ns/1ps
// I2C target byte engine: address match/ACK, write bytes to a one-entry buffer, read bytes from a valid/ready source.
// Latency: every registered output follows its cause by 1 cycle; SDA updates land thddat+1 cycles after an SCL falling strobe.
// Backpressure: SCL is stretched while the rx buffer is full (STRETCH_EN=1, else the byte is NACKed) and while no tx byte is ready.
module i2c_target_engine #(
  parameter bit STRETCH_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ena,
  input  logic [6:0]  slv_addr,
  input  logic [15:0] thddat,
  input  logic        scl_i,
  input  logic        sda_i,
  input  logic        sta_det,
  input  logic        sto_det,
  input  logic        scl_rising,
  input  logic        scl_falling,
  output logic        scl_o,
  output logic        sda_o,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic        addressed,
  output logic        rw,
  output logic        xfer_done,
  output logic        nack_det
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, RX_DATA, RX_ACK, TX_LOAD, TX_DATA, TX_ACK, WAIT_STOP
  } state_t;

  state_t      state_q;
  logic [3:0]  bit_cnt_q;
  logic [7:0]  sh_q;
  logic [15:0] hcnt_q;      // SDA hold countdown
  logic        pend_q;      // an SDA update is waiting for the hold countdown
  logic        pend_val_q;  // value that update will apply
  logic        sda_q, scl_q;
  logic [7:0]  rx_data_q;
  logic        rx_valid_q, tx_ready_q, addressed_q, rw_q;
  logic        xfer_done_q, nack_det_q;
  logic        stretch_q;   // rx byte waiting for the buffer, SCL held low
  logic        nack_q;      // current rx byte was dropped and NACKed
  logic        phase_q;     // second half of ADDR_ACK / ACK seen in TX_ACK

  // The SCL level itself is not needed here: the PHY already provides edge strobes.
  logic scl_unused;
  assign scl_unused = scl_i;

  assign scl_o     = scl_q;
  assign sda_o     = sda_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign tx_ready  = tx_ready_q;
  assign addressed = addressed_q;
  assign rw        = rw_q;
  assign xfer_done = xfer_done_q;
  assign nack_det  = nack_det_q;

  // Protocol FSM with SDA hold timer, rx buffer and tx handshake; later assignments override earlier ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      sh_q        <= '0;
      hcnt_q      <= '0;
      pend_q      <= 1'b0;
      pend_val_q  <= 1'b1;
      sda_q       <= 1'b1;
      scl_q       <= 1'b1;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      tx_ready_q  <= 1'b0;
      addressed_q <= 1'b0;
      rw_q        <= 1'b0;
      xfer_done_q <= 1'b0;
      nack_det_q  <= 1'b0;
      stretch_q   <= 1'b0;
      nack_q      <= 1'b0;
      phase_q     <= 1'b0;
    end else begin
      xfer_done_q <= 1'b0;
      nack_det_q  <= 1'b0;
      if (rx_valid_q && rx_ready) rx_valid_q <= 1'b0;

      // Hold timer: apply the pending SDA value when the countdown expires.
      if (pend_q) begin
        if (hcnt_q == 16'd0) begin
          sda_q  <= pend_val_q;
          pend_q <= 1'b0;
        end else begin
          hcnt_q <= hcnt_q - 16'd1;
        end
      end
      // A new falling strobe flushes any update still waiting, then may schedule a new one below.
      if (scl_falling && pend_q) begin
        sda_q  <= pend_val_q;
        pend_q <= 1'b0;
      end

      if (!ena) begin
        state_q     <= IDLE;
        sda_q       <= 1'b1;
        scl_q       <= 1'b1;
        pend_q      <= 1'b0;
        tx_ready_q  <= 1'b0;
        stretch_q   <= 1'b0;
        addressed_q <= 1'b0;
      end else if (sta_det) begin
        state_q     <= ADDR;
        bit_cnt_q   <= '0;
        addressed_q <= 1'b0;
        sda_q       <= 1'b1;
        scl_q       <= 1'b1;
        pend_q      <= 1'b0;
        tx_ready_q  <= 1'b0;
        stretch_q   <= 1'b0;
        nack_q      <= 1'b0;
        phase_q     <= 1'b0;
      end else if (sto_det) begin
        state_q     <= IDLE;
        sda_q       <= 1'b1;
        scl_q       <= 1'b1;
        pend_q      <= 1'b0;
        tx_ready_q  <= 1'b0;
        stretch_q   <= 1'b0;
        xfer_done_q <= addressed_q;
        addressed_q <= 1'b0;
      end else begin
        case (state_q)
          ADDR: begin
            if (scl_rising) begin
              sh_q      <= {sh_q[6:0], sda_i};
              bit_cnt_q <= bit_cnt_q + 4'd1;
              if (bit_cnt_q == 4'd7) begin
                if (sh_q[6:0] == slv_addr) begin
                  rw_q        <= sda_i;
                  addressed_q <= 1'b1;
                  phase_q     <= 1'b0;
                  state_q     <= ADDR_ACK;
                end else begin
                  state_q <= WAIT_STOP;
                end
              end
            end
          end
          ADDR_ACK: begin
            if (scl_falling) begin
              if (!phase_q) begin
                pend_q <= 1'b1; pend_val_q <= 1'b0; hcnt_q <= thddat;
                phase_q <= 1'b1;
              end else if (rw_q) begin
                pend_q <= 1'b1; pend_val_q <= 1'b1; hcnt_q <= thddat;
                tx_ready_q <= 1'b1;
                scl_q      <= tx_valid;
                state_q    <= TX_LOAD;
              end else begin
                pend_q <= 1'b1; pend_val_q <= 1'b1; hcnt_q <= thddat;
                bit_cnt_q <= '0;
                state_q   <= RX_DATA;
              end
            end
          end
          RX_DATA: begin
            if (stretch_q) begin
              if (!rx_valid_q || rx_ready) begin
                rx_data_q  <= sh_q;
                rx_valid_q <= 1'b1;
                scl_q      <= 1'b1;
                stretch_q  <= 1'b0;
                nack_q     <= 1'b0;
                pend_q <= 1'b1; pend_val_q <= 1'b0; hcnt_q <= thddat;
                state_q    <= RX_ACK;
              end
            end else if (scl_rising && !bit_cnt_q[3]) begin
              sh_q      <= {sh_q[6:0], sda_i};
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end else if (scl_falling && bit_cnt_q[3]) begin
              if (!rx_valid_q || rx_ready) begin
                rx_data_q  <= sh_q;
                rx_valid_q <= 1'b1;
                nack_q     <= 1'b0;
                pend_q <= 1'b1; pend_val_q <= 1'b0; hcnt_q <= thddat;
                state_q    <= RX_ACK;
              end else if (STRETCH_EN) begin
                scl_q     <= 1'b0;
                stretch_q <= 1'b1;
              end else begin
                nack_q  <= 1'b1;
                pend_q <= 1'b1; pend_val_q <= 1'b1; hcnt_q <= thddat;
                state_q <= RX_ACK;
              end
            end
          end
          RX_ACK: begin
            if (scl_falling) begin
              pend_q <= 1'b1; pend_val_q <= 1'b1; hcnt_q <= thddat;
              bit_cnt_q <= '0;
              state_q   <= nack_q ? WAIT_STOP : RX_DATA;
            end
          end
          TX_LOAD: begin
            if (tx_valid) begin
              sh_q       <= tx_data;
              tx_ready_q <= 1'b0;
              scl_q      <= 1'b1;
              bit_cnt_q  <= '0;
              state_q    <= TX_DATA;
              // Keep the hold timing of the falling strobe that entered this state when it is still running.
              if (pend_q && hcnt_q != 16'd0) begin
                pend_val_q <= tx_data[7];
              end else if (pend_q) begin
                sda_q <= tx_data[7];
              end else begin
                pend_q <= 1'b1; pend_val_q <= tx_data[7]; hcnt_q <= thddat;
              end
            end else begin
              scl_q <= 1'b0;
            end
          end
          TX_DATA: begin
            if (scl_falling) begin
              if (bit_cnt_q == 4'd7) begin
                pend_q <= 1'b1; pend_val_q <= 1'b1; hcnt_q <= thddat;
                bit_cnt_q <= '0;
                phase_q   <= 1'b0;
                state_q   <= TX_ACK;
              end else begin
                pend_q <= 1'b1; pend_val_q <= sh_q[6]; hcnt_q <= thddat;
                sh_q      <= {sh_q[6:0], 1'b0};
                bit_cnt_q <= bit_cnt_q + 4'd1;
              end
            end
          end
          TX_ACK: begin
            if (scl_rising) begin
              if (sda_i) begin
                nack_det_q <= 1'b1;
                state_q    <= WAIT_STOP;
              end else begin
                phase_q <= 1'b1;
              end
            end else if (scl_falling && phase_q) begin
              pend_q <= 1'b1; pend_val_q <= 1'b1; hcnt_q <= thddat;
              tx_ready_q <= 1'b1;
              scl_q      <= tx_valid;
              state_q    <= TX_LOAD;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
